// File: rtl/kamus_issue_ctrl.sv
// kamus_issue_ctrl: decode-to-execute issue control with a long-latency register scoreboard,
// outstanding-op limit, fence drain and post-redirect bubble window.
module kamus_issue_ctrl #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int FLUSH_CYCLES    = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        id_valid_i,
   output logic        id_ready_o,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        rs1_used_i,
   input  logic        rs2_used_i,
   input  logic        rd_wr_i,
   input  logic        long_lat_i,
   input  logic        fence_i,
   input  logic        ex_ready_i,
   output logic        issue_valid_o,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_addr_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic [3:0]  outstanding_o,
   output logic [31:0] busy_o
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t      state, state_nxt;
   logic [2:0]  flush_cnt, flush_cnt_nxt;
   logic [3:0]  outstanding, outstanding_nxt;
   logic [31:0] busy, busy_nxt, wb_mask, set_mask, eff_busy;
   logic        hazard, drained, lat_issue;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state       <= RUN;
         flush_cnt   <= 3'd0;
         outstanding <= 4'd0;
         busy        <= 32'd0;
      end else begin
         state       <= state_nxt;
         flush_cnt   <= flush_cnt_nxt;
         outstanding <= outstanding_nxt;
         busy        <= busy_nxt;
      end
   // A same-cycle writeback counts as already retired, for hazards and for fence drain.
   always_comb begin
      wb_mask         = wb_valid_i ? 32'd1 << wb_rd_addr_i : 32'd0;
      eff_busy        = busy & ~wb_mask;
      hazard          = (rs1_used_i & eff_busy[rs1_addr_i]) | (rs2_used_i & eff_busy[rs2_addr_i]) |
                        (rd_wr_i & eff_busy[rd_addr_i]) |
                        (long_lat_i & outstanding == 4'(MAX_OUTSTANDING) & ~wb_valid_i);
      drained         = outstanding == 4'd0 | (outstanding == 4'd1 & wb_valid_i);
      id_ready_o      = state == RUN & ex_ready_i & ~hazard & ~flush_i & (~fence_i | drained);
      issue_valid_o   = id_valid_i & id_ready_o;
      stall_o         = id_valid_i & ~id_ready_o & state == RUN & ~flush_i;
      lat_issue       = issue_valid_o & long_lat_i;
      set_mask        = (lat_issue & rd_wr_i) ? 32'd1 << rd_addr_i : 32'd0;
      busy_nxt        = (eff_busy | set_mask) & ~32'd1;
      outstanding_nxt = (lat_issue & ~wb_valid_i) ? outstanding + 4'd1 :
                        (~lat_issue & wb_valid_i & outstanding != 4'd0) ? outstanding - 4'd1 :
                        outstanding;
      state_nxt       = flush_i ? FLUSH : (state == FLUSH & flush_cnt == 3'd0) ? RUN : state;
      flush_cnt_nxt   = flush_i ? 3'(FLUSH_CYCLES - 1) :
                        (state == FLUSH & flush_cnt != 3'd0) ? flush_cnt - 3'd1 : flush_cnt;
   end
   assign outstanding_o = outstanding;
   assign busy_o        = busy;
endmodule

// File: tb/tb_kamus_issue_ctrl.sv
// tb_kamus_issue_ctrl: directed vectors; stimulus queues the expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_kamus_issue_ctrl;
   logic        clk = 0, rst_n = 0;
   logic        id_valid = 0, id_ready, rs1_used = 0, rs2_used = 0, rd_wr = 0, long_lat = 0, fence = 0;
   logic [4:0]  rs1 = 0, rs2 = 0, rd = 0, wb_rd = 0;
   logic        ex_ready = 1, issue_valid, wb_valid = 0, flush = 0, stall;
   logic [3:0]  outstanding;
   logic [31:0] busy;
   int          n_cmp = 0, n_bad = 0;

   typedef struct {string nm; logic [38:0] v;} exp_t;
   exp_t q[$];

   localparam logic [4:0] NONE = 5'b00000, LD = 5'b00110, ADD = 5'b11100, FEN = 5'b00001, WR = 5'b00100;

   kamus_issue_ctrl #(.MAX_OUTSTANDING(4), .FLUSH_CYCLES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_ready_o(id_ready),
      .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rd_addr_i(rd), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
      .rd_wr_i(rd_wr), .long_lat_i(long_lat), .fence_i(fence), .ex_ready_i(ex_ready),
      .issue_valid_o(issue_valid), .wb_valid_i(wb_valid), .wb_rd_addr_i(wb_rd), .flush_i(flush),
      .stall_o(stall), .outstanding_o(outstanding), .busy_o(busy));

   always #5 clk = ~clk;

   always @(negedge clk)
      if (q.size() != 0) begin
         exp_t e;
         logic [38:0] got;
         e   = q.pop_front();
         got = {id_ready, issue_valid, stall, outstanding, busy};
         n_cmp++;
         if (got !== e.v) begin
            n_bad++;
            $display("FAIL %s: got rdy/iss/stl=%b%b%b out=%0d busy=%h, want rdy/iss/stl=%b%b%b out=%0d busy=%h",
                     e.nm, got[38], got[37], got[36], got[35:32], got[31:0],
                     e.v[38], e.v[37], e.v[36], e.v[35:32], e.v[31:0]);
         end
      end

   // f = {rs1_used, rs2_used, rd_wr, long_lat, fence}; e = {id_ready, issue_valid, stall}
   task automatic cyc(input string nm, input logic v, input logic [4:0] r1, r2, d, f,
                      input logic exr, wbv, input logic [4:0] wbr, input logic fl,
                      input logic [2:0] e, input logic [3:0] eo, input logic [31:0] eb);
      exp_t x;
      id_valid = v; rs1 = r1; rs2 = r2; rd = d;
      {rs1_used, rs2_used, rd_wr, long_lat, fence} = f;
      ex_ready = exr; wb_valid = wbv; wb_rd = wbr; flush = fl;
      x.nm = nm; x.v = {e, eo, eb};
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      cyc("reset",       0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 0, 32'h0);
      // RAW on a load result, resolved by same-cycle writeback
      cyc("ld_x5",       1, 0, 0, 5, LD,   1, 0, 0, 0, 3'b110, 0, 32'h0);
      cyc("raw_stall1",  1, 5, 1, 6, ADD,  1, 0, 0, 0, 3'b001, 1, 32'h20);
      cyc("raw_stall2",  1, 5, 1, 6, ADD,  1, 0, 0, 0, 3'b001, 1, 32'h20);
      cyc("raw_wb_iss",  1, 5, 1, 6, ADD,  1, 1, 5, 0, 3'b110, 1, 32'h20);
      cyc("raw_clear",   0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 0, 32'h0);
      // outstanding limit
      cyc("ld_x1",       1, 0, 0, 1, LD,   1, 0, 0, 0, 3'b110, 0, 32'h0);
      cyc("ld_x2",       1, 0, 0, 2, LD,   1, 0, 0, 0, 3'b110, 1, 32'h2);
      cyc("ld_x3",       1, 0, 0, 3, LD,   1, 0, 0, 0, 3'b110, 2, 32'h6);
      cyc("ld_x4",       1, 0, 0, 4, LD,   1, 0, 0, 0, 3'b110, 3, 32'hE);
      cyc("ld5_full",    1, 0, 0, 10, LD,  1, 0, 0, 0, 3'b001, 4, 32'h1E);
      cyc("ld5_wb_iss",  1, 0, 0, 10, LD,  1, 1, 1, 0, 3'b110, 4, 32'h1E);
      cyc("full_hold",   0, 0, 0, 0, NONE, 1, 1, 2, 0, 3'b100, 4, 32'h41C);
      cyc("drain_x3",    0, 0, 0, 0, NONE, 1, 1, 3, 0, 3'b100, 3, 32'h418);
      cyc("drain_x4",    0, 0, 0, 0, NONE, 1, 1, 4, 0, 3'b100, 2, 32'h410);
      cyc("drain_x10",   0, 0, 0, 0, NONE, 1, 1, 10, 0, 3'b100, 1, 32'h400);
      cyc("drained",     0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 0, 32'h0);
      // load to x0
      cyc("ld_x0",       1, 0, 0, 0, LD,   1, 0, 0, 0, 3'b110, 0, 32'h0);
      cyc("use_x0",      1, 0, 0, 0, ADD,  1, 0, 0, 0, 3'b110, 1, 32'h0);
      cyc("wb_x0",       0, 0, 0, 0, NONE, 1, 1, 0, 0, 3'b100, 1, 32'h0);
      cyc("x0_done",     0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 0, 32'h0);
      // fence drain
      cyc("ld_x8",       1, 0, 0, 8, LD,   1, 0, 0, 0, 3'b110, 0, 32'h0);
      cyc("ld_x9",       1, 0, 0, 9, LD,   1, 0, 0, 0, 3'b110, 1, 32'h100);
      cyc("fence_wait",  1, 0, 0, 0, FEN,  1, 0, 0, 0, 3'b001, 2, 32'h300);
      cyc("fence_wb1",   1, 0, 0, 0, FEN,  1, 1, 8, 0, 3'b001, 2, 32'h300);
      cyc("fence_wb2",   1, 0, 0, 0, FEN,  1, 1, 9, 0, 3'b110, 1, 32'h200);
      cyc("fence_done",  0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 0, 32'h0);
      cyc("wb_at_zero",  0, 0, 0, 0, NONE, 1, 1, 5, 0, 3'b100, 0, 32'h0);
      cyc("zero_sat",    0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 0, 32'h0);
      // redirect bubble and reload
      cyc("flush_cyc",   1, 1, 2, 3, ADD,  1, 0, 0, 1, 3'b000, 0, 32'h0);
      cyc("bubble1",     1, 1, 2, 3, ADD,  1, 0, 0, 0, 3'b000, 0, 32'h0);
      cyc("bubble2",     1, 1, 2, 3, ADD,  1, 0, 0, 0, 3'b000, 0, 32'h0);
      cyc("run_again",   1, 1, 2, 3, ADD,  1, 0, 0, 0, 3'b110, 0, 32'h0);
      cyc("flush_a",     1, 1, 2, 3, ADD,  1, 0, 0, 1, 3'b000, 0, 32'h0);
      cyc("flush_b",     1, 1, 2, 3, ADD,  1, 0, 0, 1, 3'b000, 0, 32'h0);
      cyc("reload1",     1, 1, 2, 3, ADD,  1, 0, 0, 0, 3'b000, 0, 32'h0);
      cyc("reload2",     1, 1, 2, 3, ADD,  1, 0, 0, 0, 3'b000, 0, 32'h0);
      cyc("reload_run",  1, 1, 2, 3, ADD,  1, 0, 0, 0, 3'b110, 0, 32'h0);
      // set wins over same-cycle clear
      cyc("ld_x11",      1, 0, 0, 11, LD,  1, 0, 0, 0, 3'b110, 0, 32'h0);
      cyc("ld_x7_wb_x7", 1, 0, 0, 7, LD,   1, 1, 7, 0, 3'b110, 1, 32'h800);
      cyc("x7_set",      0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 1, 32'h880);
      cyc("wb_x11",      0, 0, 0, 0, NONE, 1, 1, 11, 0, 3'b100, 1, 32'h880);
      cyc("ex_not_rdy",  1, 1, 2, 3, ADD,  0, 0, 0, 0, 3'b001, 0, 32'h80);
      cyc("waw_x7",      1, 0, 0, 7, WR,   1, 0, 0, 0, 3'b001, 0, 32'h80);
      cyc("ld_x12",      1, 0, 0, 12, LD,  1, 0, 0, 0, 3'b110, 0, 32'h80);
      // asynchronous reset mid-operation
      rst_n = 0;
      #2 rst_n = 1;
      cyc("after_rst",   0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 0, 32'h0);
      cyc("stale_wb",    0, 0, 0, 0, NONE, 1, 1, 12, 0, 3'b100, 0, 32'h0);
      cyc("stale_sat",   0, 0, 0, 0, NONE, 1, 0, 0, 0, 3'b100, 0, 32'h0);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
